// File: rtl/sto_search_ctrl_if.sv
// Request/result bus between the STO search controller and its host.
// The master drives the request, config and metric stream; the slave returns status and results.
interface sto_search_ctrl_if #(
    parameter int IDX_W = 13,
    parameter int MET_W = 16,
    parameter int CFG_W = 12
);
    logic             start;
    logic [CFG_W-1:0] nfft;
    logic [CFG_W-1:0] ng;
    logic [CFG_W-1:0] com_delay;
    logic             metric_valid;
    logic [MET_W-1:0] metric;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] peak_idx;
    logic [MET_W-1:0] peak_val;
    logic [CFG_W-1:0] est_sto;
    logic             err;

    modport master (
        output start, nfft, ng, com_delay, metric_valid, metric,
        input  busy, done, peak_idx, peak_val, est_sto, err
    );

    modport slave (
        input  start, nfft, ng, com_delay, metric_valid, metric,
        output busy, done, peak_idx, peak_val, est_sto, err
    );
endinterface

// File: rtl/sto_search_ctrl.sv
// Sample-timing-offset search: scans an (nfft+ng)-sample timing-metric window for its peak
// and reports est_sto = (nfft+ng) - com_delay - peak_idx with a busy/done handshake.
//
// state    | meaning
// S_IDLE   | waiting for start; config latched on accept
// S_SEARCH | accepting metric samples, tracking running max and its index
// S_CALC   | one cycle; estimate computed, results registered on exit
module sto_search_ctrl #(
    parameter int IDX_W = 13,
    parameter int MET_W = 16,
    parameter int CFG_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sto_search_ctrl_if.slave     bus
);

    localparam int PAD = IDX_W - CFG_W;
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_CALC
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [MET_W-1:0] max_q;
    logic [CFG_W-1:0] com_q;
    logic             zero_q;

    logic [IDX_W-1:0] win_d;
    logic             accept;
    logic             take;
    logic [IDX_W:0]   diff;

    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [IDX_W-1:0] peak_idx_q;
    logic [MET_W-1:0] peak_val_q;
    logic [CFG_W-1:0] est_sto_q;

    // Window length at IDX_W bits: two CFG_W operands cannot overflow it.
    assign win_d = {{PAD{1'b0}}, bus.nfft} + {{PAD{1'b0}}, bus.ng};

    assign diff = {1'b0, win_q}
                - {{(PAD+1){1'b0}}, com_q}
                - {1'b0, idx_q};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (win_d == '0) ? S_CALC : S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (bus.metric_valid) begin
                    take = 1'b1;
                    if (cnt_q == win_q - IDX_ONE) begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            max_q  <= '0;
            com_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            win_q  <= win_d;
            com_q  <= bus.com_delay;
            zero_q <= (win_d == '0);
            cnt_q  <= '0;
            idx_q  <= '0;
            max_q  <= '0;
        end else if (take) begin
            cnt_q <= cnt_q + IDX_ONE;
            // Strict compare keeps the earliest index on ties.
            if (cnt_q == '0 || bus.metric > max_q) begin
                max_q <= bus.metric;
                idx_q <= cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            peak_idx_q <= '0;
            peak_val_q <= '0;
            est_sto_q  <= '0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_q == S_CALC);
            if (state_q == S_CALC) begin
                err_q <= zero_q | diff[IDX_W];
                if (zero_q) begin
                    peak_idx_q <= '0;
                    peak_val_q <= '0;
                    est_sto_q  <= '0;
                end else begin
                    peak_idx_q <= idx_q;
                    peak_val_q <= max_q;
                    est_sto_q  <= diff[CFG_W-1:0];
                end
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.peak_idx = peak_idx_q;
    assign bus.peak_val = peak_val_q;
    assign bus.est_sto  = est_sto_q;

endmodule

// File: doc/sto_search_ctrl.md
Name: sto_search_ctrl

Overview:
- Sequences one sample-timing-offset (STO) estimation per request.
- Latches the symbol configuration, then scans a window of Nfft+Ng timing-metric samples from the upstream correlator and tracks the peak index.
- Computes est_sto = (Nfft+Ng) - com_delay - peak_idx and reports it with a busy/done handshake.
- Sits between the CP-correlation metric datapath and the frame-sync / FFT-window alignment logic.

Parameters:
- IDX_W, 13, width of the window counter and peak index; must hold up to 2*4095.
- MET_W, 16, width of the unsigned timing metric.
- CFG_W, 12, width of nfft, ng, com_delay and est_sto.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- nfft  input  CFG_W  FFT size; latched on accepted start.
- ng  input  CFG_W  cyclic-prefix length; latched on accepted start.
- com_delay  input  CFG_W  pipeline compensation delay; latched on accepted start.
- metric_valid  input  1  metric sample strobe.
- metric  input  MET_W  unsigned timing metric.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result outputs valid.
- peak_idx  output  IDX_W  window index of the maximum metric.
- peak_val  output  MET_W  maximum metric value.
- est_sto  output  CFG_W  STO estimate.
- err  output  1  qualifies done: zero-length window or negative estimate.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy, done, err, peak_idx, peak_val and est_sto all 0. Takes effect immediately, including mid-search; no partial result and no done are produced.
- FSM states: IDLE, SEARCH, CALC.
- IDLE:
  - start=1: latch nfft, ng and com_delay; W = nfft+ng, IDX_W bits, no overflow; clear the counter, running max and running index.
  - If W==0: go to CALC with zero-window flag set.
  - Otherwise go to SEARCH.
  - busy rises at the next edge.
- SEARCH:
  - Each cycle with metric_valid=1 accepts one sample at index cnt, then cnt increments.
  - Cycles with metric_valid=0 are ignored; gaps are allowed.
  - First sample (cnt==0) loads max=metric, idx=0 unconditionally.
  - After that, update only on metric > max (strict), so the earliest index wins ties.
  - On acceptance of sample cnt==W-1, go to CALC. Later samples are ignored until the next start.
- CALC (one cycle):
  - diff = W - com_delay - idx, computed at IDX_W+1 bits signed.
  - est_sto = diff[CFG_W-1:0], modulo 2^CFG_W wrap.
  - err=1 if diff<0 or the zero-window flag is set; else err=0.
  - If the zero-window flag is set: peak_idx=0, peak_val=0, est_sto=0.
  - At the edge leaving CALC: outputs register, done=1 for exactly one cycle, busy=0, FSM returns to IDLE.
- Latency: done is high in the 2nd cycle after the clock edge that accepts the last window sample.
- Holding: est_sto, peak_idx, peak_val and err hold their values until the next CALC; err is not cleared on start.
- start while busy: ignored, not queued.
- start in the same cycle done is high: accepted, because the FSM is in IDLE.
- Config inputs may change freely while busy; only the latched copies are used.

Test Plan:
- nfft=64, ng=16, com_delay=0; 80 valid samples, metric=100 at idx 10, else 5 -> peak_idx=10, peak_val=100, est_sto=70, err=0; done exactly 2 cycles after the 80th sample edge; busy high throughout.
- Same config, metric=200 at idx 5 and idx 20, else 0 -> peak_idx=5 (earliest wins tie), est_sto=75.
- nfft=64, ng=16, com_delay=8, peak at idx 79 -> diff=-7 -> est_sto=4089, err=1.
- nfft=0, ng=0, start -> done 2 cycles after start, err=1, est_sto=0, no samples consumed.
- metric_valid toggling 1/0 every cycle, nfft=8, ng=2, peak at idx 3 -> done after the 10th valid sample, peak_idx=3, est_sto=7.
- rst_n pulsed low at sample 30 of an 80-sample search -> all outputs 0 immediately, no done. Repeated start during busy ignored. A new start after reset completes normally with correct results.
